pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised elastic pipeline register that replaces fixed per-stage register banks between adjacent core pipeline stages (e.g. execute→memory). It carries a resettable control field, a non-critical bulk payload and a forwardable store-data field. Transfer uses a valid/ready handshake with flush. An optional two-entry skid buffer removes the combinational ready path. While an entry is held, its forward field is refreshed from the bypass network, so stalled store data never goes stale.

## Interface
Parameters:
- `CTRL_WIDTH`, 8: control/status bits (issued, exception, regwrite, …); cleared on reset and flush.
- `DATA_WIDTH`, 96: bulk payload (PC, ALU result, bad vaddr, …).
- `FWD_WIDTH`, 32: forward-updatable field (store write data).

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `flush`  in  1  discard all held entries.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage accepts an entry this cycle.
- `in_ctrl`  in  CTRL_WIDTH  upstream control field.
- `in_data`  in  DATA_WIDTH  upstream payload.
- `in_fwd`  in  FWD_WIDTH  upstream forwardable field.
- `fwd_valid`  in  1  bypass value for the head entry is valid.
- `fwd_data`  in  FWD_WIDTH  bypass value.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  downstream consumes head.
- `out_ctrl`  out  CTRL_WIDTH  head control field.
- `out_data`  out  DATA_WIDTH  head payload.
- `out_fwd`  out  FWD_WIDTH  head forwardable field.
- `occupancy`  out  2  entries held (0–2).

## Operation
- Accept: `in_valid & in_ready`. Consume: `out_valid & out_ready`.
- Entries: HEAD always; SKID only when `PIPE_SKID_EN` is defined.
- States (skid build): EMPTY(0), ONE(head valid), TWO(head+skid valid).
- EMPTY --accept--> ONE.
- ONE --accept & ~consume--> TWO, with the new entry written to SKID.
- ONE --consume & ~accept--> EMPTY.
- ONE --accept & consume--> ONE, with the new entry written to HEAD.
- TWO --consume--> ONE, with SKID moved to HEAD. No accept is possible in TWO.
- Skid-build ready: `in_ready = ~skid_valid & ~flush`. It is registered-state-derived, with no path from `out_ready`.
- Non-skid build: single entry; `in_ready = (~out_valid | out_ready) & ~flush`.
- Forward refresh: when head is valid and not consumed and `fwd_valid`=1, head fwd ← `fwd_data`.
  - SKID fwd is never refreshed.
  - An entry moving SKID→HEAD takes its stored fwd value. Refresh resumes the next cycle.
- Flush, highest priority:
  - Next edge clears all valid bits and ctrl fields.
  - `in_ready`=0 during flush, so no entry is accepted.
  - `out_valid` is unaffected in the flush cycle; a consume in that cycle is still honoured.
- Payload `data`/`fwd` are not altered by flush.

## Timing
- Latency: 1 cycle from accept to `out_valid` (EMPTY→ONE). Throughput: 1 entry/cycle when `out_ready` is held high.
- All outputs are registered except `in_ready` in the non-skid build.
- Reset (async assert, sync deassert by the system):
  - `out_valid`=0, `occupancy`=0.
  - `out_ctrl`, `out_data`, `out_fwd` = 0.
  - `in_ready`=1 once `reset`=1.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush or reset.

## Configuration
- `PIPE_SKID_EN` defined:
  - two-entry elastic buffer.
  - `in_ready` is independent of `out_ready`.
  - `occupancy` ranges 0–2.
- `PIPE_SKID_EN` undefined:
  - single HEAD entry.
  - `in_ready` combinationally depends on `out_ready`.
  - `occupancy` ranges 0–1 (bit 1 tied 0).
  - Behaviour is equivalent to a stall/flush-enabled pipeline register.

## Test plan
- Reset, then streaming: reset=0, then 1. Push ctrl 0x01–0x05 with `out_ready`=1 every cycle → each appears on `out_ctrl` one cycle after accept, `occupancy`=1 throughout.
- Backpressure (skid): hold `out_ready`=0 and push A, B, C → A and B accepted, `in_ready`=0 after B, `occupancy`=2. Release → A, then B, then C, in order.
- Forward refresh: head fwd=0x11111111, `out_ready`=0 for 3 cycles with `fwd_data`=0xAAAA0001, 0xAAAA0002, 0xAAAA0003 → `out_fwd`=0xAAAA0003 at consume. SKID entry keeps its original value.
- Flush in TWO with `in_valid`=1 → next cycle `out_valid`=0, `occupancy`=0, `out_ctrl`=0. The flushed-cycle input is not accepted.
- Async reset mid-stream: assert reset between edges with `occupancy`=2 → `out_valid`=0 and outputs=0 before the next edge.
- Non-skid build: `out_ready`=0 with head valid → `in_ready`=0 in the same cycle. Raise `out_ready` → `in_ready`=1 combinationally, with accept and consume in the same cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with a forward-refreshed store-data field.
// Define PIPE_SKID_EN for the two-entry skid build (registered in_ready).
module pipe_stage_reg #(
  parameter int CTRL_WIDTH = 8,
  parameter int DATA_WIDTH = 96,
  parameter int FWD_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [FWD_WIDTH-1:0]  in_fwd,
  input  logic                  fwd_valid,
  input  logic [FWD_WIDTH-1:0]  fwd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [FWD_WIDTH-1:0]  out_fwd,
  output logic [1:0]            occupancy
);

  logic                  head_valid;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;
  logic [FWD_WIDTH-1:0]  head_fwd;

  logic accept;
  logic consume;
  logic refresh;

  assign out_valid = head_valid;
  assign out_ctrl  = head_ctrl;
  assign out_data  = head_data;
  assign out_fwd   = head_fwd;

  assign accept  = in_valid & in_ready;
  assign consume = head_valid & out_ready;
  // Only a head that stays put picks up the bypass value.
  assign refresh = head_valid & ~consume & fwd_valid;

`ifdef PIPE_SKID_EN

  logic                  skid_valid;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [FWD_WIDTH-1:0]  skid_fwd;

  assign in_ready  = ~skid_valid & ~flush;
  assign occupancy = {skid_valid, head_valid & ~skid_valid};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_valid <= 1'b0;
      head_ctrl  <= '0;
      head_data  <= '0;
      head_fwd   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      skid_fwd   <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      head_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (skid_valid) begin
      if (consume) begin
        head_ctrl  <= skid_ctrl;
        head_data  <= skid_data;
        head_fwd   <= skid_fwd;
        skid_valid <= 1'b0;
      end else if (refresh) begin
        head_fwd <= fwd_data;
      end
    end else if (accept && head_valid && !consume) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
      skid_fwd   <= in_fwd;
      if (refresh) begin
        head_fwd <= fwd_data;
      end
    end else if (accept) begin
      head_valid <= 1'b1;
      head_ctrl  <= in_ctrl;
      head_data  <= in_data;
      head_fwd   <= in_fwd;
    end else if (consume) begin
      head_valid <= 1'b0;
    end else if (refresh) begin
      head_fwd <= fwd_data;
    end
  end

`else

  assign in_ready  = (~head_valid | out_ready) & ~flush;
  assign occupancy = {1'b0, head_valid};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_valid <= 1'b0;
      head_ctrl  <= '0;
      head_data  <= '0;
      head_fwd   <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      head_ctrl  <= '0;
    end else if (accept) begin
      head_valid <= 1'b1;
      head_ctrl  <= in_ctrl;
      head_data  <= in_data;
      head_fwd   <= in_fwd;
    end else if (consume) begin
      head_valid <= 1'b0;
    end else if (refresh) begin
      head_fwd <= fwd_data;
    end
  end

`endif

endmodule
